mips_mdu: RTL
=============

Name: mips_mdu

Overview:
- Multi-cycle multiply/divide unit for the EX stage of the MIPS core.
- Sits beside the ALU and is fed the same rs/rt operand buses (A, B).
- Its HI/LO outputs feed the EX result mux that also takes the ALU result, used by mfhi/mflo.
- Owns the architectural HI/LO registers and raises busy so the hazard unit stalls mult/div/mfhi/mflo/mthi/mtlo.

Parameters:
- MUL_CYCLES, 5, cycles busy stays high for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, cycles busy stays high for div/divu (legal range 1..15).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; clears all state immediately when low.
- start  in  1  one-cycle request qualifier for mdu_op.
- mdu_op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others reserved (no-op).
- A  in  32  rs operand: multiplicand, dividend, or the value for mthi/mtlo.
- B  in  32  rt operand: multiplier or divisor.
- busy  out  1  high while a mult/div is in flight.
- hi  out  32  architectural HI register.
- lo  out  32  architectural LO register.

Behaviour:
- Reset (reset low, asynchronous): hi=0, lo=0, busy=0, state IDLE, counter=0, latched result=0.
- States: IDLE, MUL, DIV.
- Accept rule: a request is accepted only when start=1 and state==IDLE at a rising edge.
  - A start while busy=1 is ignored; the in-flight operation is unaffected and hi/lo are not touched.
  - A reserved mdu_op is ignored.
- MTHI / MTLO:
  - Accepted at edge k: hi (or lo) <= A at edge k.
  - busy stays 0 and the state stays IDLE.
- MULT / MULTU / DIV / DIVU accepted at edge k:
  - A, B and op are latched; the counter is loaded with MUL_CYCLES or DIV_CYCLES; state goes to MUL or DIV.
  - busy=1 from edge k until edge k+N, where N is the cycle count.
  - At edge k+N: hi/lo are written, busy returns to 0, state returns to IDLE.
  - A new start is accepted at edge k+N+1 at the earliest; start at edge k+N is still ignored.
  - hi/lo hold their old values for the whole busy window.
- Arithmetic:
  - MULT: {hi,lo} = signed(A) × signed(B), full 64-bit product.
  - MULTU: {hi,lo} = unsigned 64-bit product.
  - DIV: lo = quotient, truncated toward zero; hi = remainder, with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - DIV with A=0x80000000 and B=0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (B=0 on DIV/DIVU):
  - Still runs the full DIV_CYCLES with busy high.
  - hi/lo are left unchanged at completion.
- Result source: the result may be computed combinationally from the latched operands or iteratively. Only the observable timing above is specified.
- Reset mid-operation: the operation is aborted, hi/lo=0, busy=0 immediately; no later write occurs.
- busy is a registered output, not combinational from start.

Test Plan:
- Reset, then mthi with A=0x12345678, then mtlo with A=0x9ABCDEF0 -> hi=0x12345678, lo=0x9ABCDEF0 one edge after each; busy stays 0.
- MULT with A=0xFFFFFFFE (-2), B=0x00000003 -> busy high for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV with A=0xFFFFFFF9 (-7), B=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with A=7, B=2 -> lo=3, hi=1.
- DIV with B=0 (prior hi=0xAAAA0000, lo=0x0000BBBB) -> busy 10 cycles, then hi/lo unchanged. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULT in flight, then start=1 with MTHI A=0xDEADBEEF on busy cycle 2 -> ignored; final hi/lo equal the MULT result only. start on the completion edge is also ignored.
- DIVU started, then reset pulsed low for half a cycle at busy cycle 4 -> busy=0, hi=lo=0 immediately; no update occurs at the original completion time.

Source files
------------

// File: rtl/mips_mdu.sv
// Multi-cycle multiply/divide unit for the MIPS EX stage.
// Owns the architectural HI/LO registers and holds busy high while a mult/div is in flight.
module mips_mdu #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        sgn_p0;
  logic [31:0] a_p0;
  logic [31:0] b_p0;
  logic [63:0] res;

  // Low 64 bits of the product of the extended operands are exact for both signednesses.
  function automatic logic [63:0] mul_full(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
    logic signed [63:0] ea;
    logic signed [63:0] eb;
    logic signed [63:0] p;
    ea = sgn ? signed'({{32{a[31]}}, a}) : signed'({32'b0, a});
    eb = sgn ? signed'({{32{b[31]}}, b}) : signed'({32'b0, b});
    p  = ea * eb;
    return unsigned'(p);
  endfunction

  // Divides magnitudes, then restores signs; 0x80000000 / -1 wraps to 0x80000000, rem 0.
  function automatic logic [63:0] div_rq(input logic [31:0] a, input logic [31:0] b,
                                         input logic sgn);
    logic        neg_a;
    logic        neg_b;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] q;
    logic [31:0] r;
    neg_a = sgn & a[31];
    neg_b = sgn & b[31];
    ma    = neg_a ? -a : a;
    mb    = neg_b ? -b : b;
    if (mb == 32'd0) mb = 32'd1;
    q = ma / mb;
    r = ma % mb;
    if (neg_a ^ neg_b) q = -q;
    if (neg_a) r = -r;
    return {r, q};
  endfunction

  always_comb begin
    res = '0;
    if (state == DIV) res = div_rq(a_p0, b_p0, sgn_p0);
    else              res = mul_full(a_p0, b_p0, sgn_p0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      cnt    <= 4'd0;
      sgn_p0 <= 1'b0;
      a_p0   <= '0;
      b_p0   <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (mdu_op)
              3'b000, 3'b001: begin
                state  <= MUL;
                busy   <= 1'b1;
                cnt    <= 4'(MUL_CYCLES);
                sgn_p0 <= ~mdu_op[0];
                a_p0   <= A;
                b_p0   <= B;
              end
              3'b010, 3'b011: begin
                state  <= DIV;
                busy   <= 1'b1;
                cnt    <= 4'(DIV_CYCLES);
                sgn_p0 <= ~mdu_op[0];
                a_p0   <= A;
                b_p0   <= B;
              end
              3'b100:  hi <= A;
              3'b101:  lo <= A;
              default: ;
            endcase
          end
        end
        MUL, DIV: begin
          // cnt == 1 marks the Nth edge after acceptance: retire the result.
          if (cnt == 4'd1) begin
            if (state == MUL || b_p0 != 32'd0) begin
              hi <= res[63:32];
              lo <= res[31:0];
            end
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
